// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter and the mouse receive path.
package ps2_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRts,
    StStart,
    StData,
    StAck,
    StWaitRel
  } ps2_tx_state_e;

  function automatic int unsigned calc_n_inh(input int unsigned clk_freq_hz,
                                             input int unsigned inhibit_us);
    return (clk_freq_hz / 1_000_000) * inhibit_us;
  endfunction

  function automatic int unsigned calc_n_to(input int unsigned clk_freq_hz,
                                            input int unsigned timeout_ms);
    return (clk_freq_hz / 1000) * timeout_ms;
  endfunction

  localparam int unsigned N_INH = calc_n_inh(50_000_000, 100);
  localparam int unsigned N_TO  = calc_n_to(50_000_000, 15);

  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command/status handshake between a controller and the PS/2 host transmitter.
interface ps2_host_tx_if;
  import ps2_pkg::*;

  logic       wr_ps2;
  logic [7:0] din;
  logic       tx_idle;
  logic       tx_done_tick;
  logic       ack_err;
  logic       timeout_err;

  modport master (
    output wr_ps2,
    output din,
    input  tx_idle,
    input  tx_done_tick,
    input  ack_err,
    input  timeout_err
  );

  modport slave (
    input  wr_ps2,
    input  din,
    output tx_idle,
    output tx_done_tick,
    output ack_err,
    output timeout_err
  );

endinterface

// File: rtl/ps2_clk_filter.sv
// Synchronises and deglitches the PS/2 clock line and flags its falling edges.
module ps2_clk_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c_raw,
  output logic ps2c_filt,
  output logic fall_tick
);

  localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(FILTER_LEN - 1);

  logic            meta_q, sync_q;
  logic            filt_q, filt_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Idle bus is high, so everything resets to 1 to avoid a spurious edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      meta_q <= ps2c_raw;
      sync_q <= meta_q;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q != filt_q) begin
      if (cnt_q == CntMax) begin
        filt_d = sync_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  assign ps2c_filt = filt_q;
  assign fall_tick = filt_q & ~filt_d;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, device-clocked frame, ack check.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned INHIBIT_US  = 100,
  parameter int unsigned TIMEOUT_MS  = 15,
  parameter int unsigned FILTER_LEN  = 8
) (
  input  logic         clk,
  input  logic         reset,
  ps2_host_tx_if.slave bus,
  inout  wire          ps2c,
  inout  wire          ps2d
);

  localparam int unsigned NInh = calc_n_inh(CLK_FREQ_HZ, INHIBIT_US);
  localparam int unsigned NTo  = calc_n_to(CLK_FREQ_HZ, TIMEOUT_MS);
  localparam int unsigned InhW = $clog2(NInh + 1);
  localparam int unsigned ToW  = $clog2(NTo + 1);

  ps2_tx_state_e   state_q, state_d;
  logic [8:0]      sh_q, sh_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [InhW-1:0] inh_cnt_q, inh_cnt_d;
  logic [ToW-1:0]  to_cnt_q, to_cnt_d;
  logic            d_rel_q, d_rel_d;
  logic            ack_err_q, ack_err_d;
  logic            timeout_err_q, timeout_err_d;
  logic            d_meta_q, d_sync_q;

  logic ps2c_filt, fall_tick;
  logic timeout_hit, rel_done;
  logic c_low, d_low;

  ps2_clk_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .clk      (clk),
    .reset    (reset),
    .ps2c_raw (ps2c),
    .ps2c_filt(ps2c_filt),
    .fall_tick(fall_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_q          <= '0;
      bit_cnt_q     <= '0;
      inh_cnt_q     <= '0;
      to_cnt_q      <= '0;
      d_rel_q       <= 1'b1;
      ack_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      d_meta_q      <= 1'b1;
      d_sync_q      <= 1'b1;
    end else begin
      sh_q          <= sh_d;
      bit_cnt_q     <= bit_cnt_d;
      inh_cnt_q     <= inh_cnt_d;
      to_cnt_q      <= to_cnt_d;
      d_rel_q       <= d_rel_d;
      ack_err_q     <= ack_err_d;
      timeout_err_q <= timeout_err_d;
      d_meta_q      <= ps2d;
      d_sync_q      <= d_meta_q;
    end
  end

  assign timeout_hit = (state_q inside {StStart, StData, StAck, StWaitRel}) &&
                       (to_cnt_q == ToW'(1));
  assign rel_done    = (state_q == StWaitRel) && ps2c_filt && d_sync_q;

  always_comb begin
    state_d       = state_q;
    sh_d          = sh_q;
    bit_cnt_d     = bit_cnt_q;
    inh_cnt_d     = inh_cnt_q;
    to_cnt_d      = to_cnt_q;
    d_rel_d       = d_rel_q;
    ack_err_d     = ack_err_q;
    timeout_err_d = timeout_err_q;

    if (state_q inside {StStart, StData, StAck, StWaitRel}) begin
      to_cnt_d = to_cnt_q - ToW'(1);
    end

    // Timeout wins over any edge arriving in the same cycle.
    if (timeout_hit) begin
      state_d       = StIdle;
      d_rel_d       = 1'b1;
      timeout_err_d = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.wr_ps2) begin
            sh_d          = {odd_parity(bus.din), bus.din};
            ack_err_d     = 1'b0;
            timeout_err_d = 1'b0;
            inh_cnt_d     = InhW'(NInh - 1);
            state_d       = StRts;
          end
        end
        StRts: begin
          if (inh_cnt_q == '0) begin
            d_rel_d  = 1'b0;
            to_cnt_d = ToW'(NTo);
            state_d  = StStart;
          end else begin
            inh_cnt_d = inh_cnt_q - InhW'(1);
          end
        end
        StStart: begin
          if (fall_tick) begin
            d_rel_d   = sh_q[0];
            bit_cnt_d = 4'd8;
            state_d   = StData;
          end
        end
        StData: begin
          if (fall_tick) begin
            if (bit_cnt_q == 4'd0) begin
              d_rel_d = 1'b1;
              state_d = StAck;
            end else begin
              sh_d      = {1'b1, sh_q[8:1]};
              d_rel_d   = sh_q[1];
              bit_cnt_d = bit_cnt_q - 4'd1;
            end
          end
        end
        StAck: begin
          if (fall_tick) begin
            ack_err_d = d_sync_q;
            state_d   = StWaitRel;
          end
        end
        StWaitRel: begin
          if (rel_done) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Start bit goes out in the last inhibit cycle so data is already low at clock release.
  always_comb begin
    c_low            = (state_q == StRts);
    d_low            = ~d_rel_q | ((state_q == StRts) && (inh_cnt_q == '0));
    bus.tx_idle      = (state_q == StIdle) & d_rel_q;
    bus.tx_done_tick = timeout_hit | rel_done;
    bus.ack_err      = ack_err_q;
    bus.timeout_err  = timeout_err_q;
  end

  assign ps2c = c_low ? 1'b0 : 1'bz;
  assign ps2d = d_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a cycle-based PS/2 device model on pulled-up lines.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  // 1 MHz clock makes 1 us = 1 cycle; 12.5 kHz device clock is 80 cycles.
  localparam int NInh    = 5000;
  localparam int NTo     = 10000;
  localparam int HalfPer = 40;

  logic clk = 1'b0;
  logic reset;
  logic dev_c_low, dev_d_low;
  wire  ps2c, ps2d;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  ps2_host_tx_if bus ();

  assign ps2c = dev_c_low ? 1'b0 : 1'bz;
  assign ps2d = dev_d_low ? 1'b0 : 1'bz;
  pullup (ps2c);
  pullup (ps2d);

  ps2_host_tx #(
    .CLK_FREQ_HZ(1_000_000),
    .INHIBIT_US (5000),
    .TIMEOUT_MS (10),
    .FILTER_LEN (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .ps2c (ps2c),
    .ps2d (ps2d)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.tx_done_tick === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic start_tx(input logic [7:0] b);
    @(negedge clk);
    bus.din    = b;
    bus.wr_ps2 = 1'b1;
    @(negedge clk);
    bus.wr_ps2 = 1'b0;
  endtask

  // Waits for request-to-send, then clocks n_clk pulses; captures bits 0..7, parity, stop.
  task automatic device_frame(input int n_clk, input logic ack_low, input logic glitch,
                              output logic [9:0] bits);
    int waited;
    bits   = '0;
    waited = 0;
    while (!(ps2c === 1'b1 && ps2d === 1'b0) && waited < 8000) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 8000) begin
      checks++;
      failures++;
      $display("FAIL device_rts_wait: waited %0d cycles, required request-to-send", waited);
      return;
    end
    repeat (HalfPer) @(negedge clk);
    for (int i = 0; i < n_clk; i++) begin
      if (i == 10 && ack_low) dev_d_low = 1'b1;
      dev_c_low = 1'b1;
      repeat (HalfPer) @(negedge clk);
      if (i < 10) bits[i] = ps2d;
      dev_c_low = 1'b0;
      if (glitch) begin
        repeat (15) @(negedge clk);
        dev_c_low = 1'b1;
        repeat (3) @(negedge clk);
        dev_c_low = 1'b0;
        repeat (HalfPer - 18) @(negedge clk);
      end else begin
        repeat (HalfPer) @(negedge clk);
      end
      if (i == 10) dev_d_low = 1'b0;
    end
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    while (bus.tx_idle !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    ok = (bus.tx_idle === 1'b1);
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    dev_c_low = 1'b0;
    dev_d_low = 1'b0;
    bus.wr_ps2 = 1'b0;
    bus.din    = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.tx_idle !== 1'b1) begin
      failures++; $display("FAIL reset_tx_idle: got %b, expected 1", bus.tx_idle);
    end
    checks++;
    if ({bus.tx_done_tick, bus.ack_err, bus.timeout_err} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags: got %b, expected 000",
               {bus.tx_done_tick, bus.ack_err, bus.timeout_err});
    end
    checks++;
    if ({ps2c, ps2d} !== 2'b11) begin
      failures++; $display("FAIL reset_lines: got %b, expected 11", {ps2c, ps2d});
    end
  endtask

  task automatic test_send_enable();
    logic [9:0] bits;
    bit ok;
    int base = done_cnt;
    start_tx(CMD_ENABLE);
    checks++;
    if (bus.tx_idle !== 1'b0) begin
      failures++; $display("FAIL f4_busy: tx_idle got %b, expected 0", bus.tx_idle);
    end
    device_frame(11, 1'b1, 1'b0, bits);
    wait_idle(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL f4_idle: tx_idle got 0, expected 1"); end
    checks++;
    if (bits !== 10'h2F4) begin
      failures++; $display("FAIL f4_bits: got %h, expected 2f4", bits);
    end
    checks++;
    if (done_cnt - base !== 1) begin
      failures++; $display("FAIL f4_done: got %0d pulses, expected 1", done_cnt - base);
    end
    checks++;
    if ({bus.ack_err, bus.timeout_err} !== 2'b00) begin
      failures++;
      $display("FAIL f4_errs: got %b, expected 00", {bus.ack_err, bus.timeout_err});
    end
  endtask

  task automatic test_send_reset_cmd();
    logic [9:0] bits;
    bit   ok;
    int   n_low = 0;
    logic d_at_rel = 1'b1;
    int   base = done_cnt;
    start_tx(CMD_RESET);
    fork
      begin
        while (ps2c === 1'b0 && n_low < 6000) begin
          n_low++;
          @(negedge clk);
        end
        d_at_rel = ps2d;
      end
      device_frame(11, 1'b1, 1'b0, bits);
    join
    wait_idle(ok);
    checks++;
    if (n_low !== NInh) begin
      failures++; $display("FAIL ff_inhibit: got %0d cycles low, expected %0d", n_low, NInh);
    end
    checks++;
    if (d_at_rel !== 1'b0) begin
      failures++; $display("FAIL ff_start_bit: ps2d got %b at release, expected 0", d_at_rel);
    end
    checks++;
    if (bits !== 10'h3FF) begin
      failures++; $display("FAIL ff_bits: got %h, expected 3ff", bits);
    end
    checks++;
    if (!ok || done_cnt - base !== 1) begin
      failures++;
      $display("FAIL ff_done: idle=%b pulses=%0d, expected 1 and 1", ok, done_cnt - base);
    end
  endtask

  task automatic test_ack_err();
    logic [9:0] bits;
    bit ok;
    start_tx(8'h3C);
    device_frame(11, 1'b0, 1'b0, bits);
    wait_idle(ok);
    checks++;
    if (!ok || bus.ack_err !== 1'b1) begin
      failures++; $display("FAIL ackerr_set: idle=%b ack_err=%b, expected 1 1", ok, bus.ack_err);
    end
    checks++;
    if (bits !== 10'h33C) begin
      failures++; $display("FAIL ackerr_bits: got %h, expected 33c", bits);
    end
    start_tx(CMD_ENABLE);
    checks++;
    if (bus.ack_err !== 1'b0) begin
      failures++; $display("FAIL ackerr_clear: got %b, expected 0", bus.ack_err);
    end
    device_frame(11, 1'b1, 1'b0, bits);
    wait_idle(ok);
    checks++;
    if (!ok || bus.ack_err !== 1'b0) begin
      failures++; $display("FAIL ackerr_after: idle=%b ack_err=%b, expected 1 0", ok, bus.ack_err);
    end
  endtask

  task automatic test_timeout();
    int k = 0;
    int k_done = -1;
    int base = done_cnt;
    start_tx(CMD_RESET);
    while (ps2c !== 1'b1 && k < 6000) begin
      @(negedge clk);
      k++;
    end
    k = 0;
    while (bus.timeout_err !== 1'b1 && k < NTo + 100) begin
      @(negedge clk);
      k++;
      if (bus.tx_done_tick === 1'b1 && k_done < 0) k_done = k;
    end
    checks++;
    if (k !== NTo) begin
      failures++; $display("FAIL to_err_cycle: got %0d, expected %0d", k, NTo);
    end
    checks++;
    if (k_done !== NTo - 1) begin
      failures++; $display("FAIL to_done_cycle: got %0d, expected %0d", k_done, NTo - 1);
    end
    checks++;
    if ({ps2c, ps2d, bus.tx_idle} !== 3'b111) begin
      failures++; $display("FAIL to_lines: got %b, expected 111", {ps2c, ps2d, bus.tx_idle});
    end
    checks++;
    if (done_cnt - base !== 1) begin
      failures++; $display("FAIL to_done: got %0d pulses, expected 1", done_cnt - base);
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] bits;
    bit ok;
    int base = done_cnt;
    start_tx(CMD_ENABLE);
    device_frame(4, 1'b1, 1'b0, bits);
    checks++;
    if (ps2d !== 1'b0) begin
      failures++; $display("FAIL mid_bit3: ps2d got %b, expected 0", ps2d);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({ps2c, ps2d, bus.tx_idle} !== 3'b111) begin
      failures++; $display("FAIL mid_reset: got %b, expected 111", {ps2c, ps2d, bus.tx_idle});
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt !== base) begin
      failures++; $display("FAIL mid_no_done: got %0d pulses, expected 0", done_cnt - base);
    end
    start_tx(CMD_ENABLE);
    device_frame(11, 1'b1, 1'b0, bits);
    wait_idle(ok);
    checks++;
    if (!ok || bits !== 10'h2F4 || done_cnt - base !== 1) begin
      failures++;
      $display("FAIL mid_resend: idle=%b bits=%h pulses=%0d, expected 1 2f4 1",
               ok, bits, done_cnt - base);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] bits;
    bit ok;
    int base = done_cnt;
    start_tx(8'hA5);
    fork
      device_frame(11, 1'b1, 1'b1, bits);
      begin
        repeat (NInh + 300) @(negedge clk);
        bus.din    = 8'h00;
        bus.wr_ps2 = 1'b1;
        @(negedge clk);
        bus.wr_ps2 = 1'b0;
      end
    join
    wait_idle(ok);
    checks++;
    if (bits !== 10'h3A5) begin
      failures++; $display("FAIL b2b_bits: got %h, expected 3a5", bits);
    end
    checks++;
    if (!ok || done_cnt - base !== 1 || bus.ack_err !== 1'b0) begin
      failures++;
      $display("FAIL b2b_done: idle=%b pulses=%0d ack_err=%b, expected 1 1 0",
               ok, done_cnt - base, bus.ack_err);
    end
    repeat (50) @(negedge clk);
    checks++;
    if ({bus.tx_idle, ps2c} !== 2'b11) begin
      failures++; $display("FAIL b2b_stale: got %b, expected 11", {bus.tx_idle, ps2c});
    end
  endtask

  initial begin
    test_reset();
    test_send_enable();
    test_send_reset_cmd();
    test_ack_err();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
